// File: rtl/btn_shift_ctrl.sv
// btn_shift_ctrl: shifts one bit into a W-bit register per debounced button
// press, with auto-repeat after a long hold. Parallel load overrides the
// register value without disturbing the press/repeat timing.
module btn_shift_ctrl #(
    parameter int W      = 8,
    parameter int HOLD_N = 10,
    parameter int REP_N  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn,
    input  logic         dir,
    input  logic         din,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         shift_pulse,
    output logic         held
);

    localparam int MAXN = (HOLD_N > REP_N) ? HOLD_N : REP_N;
    localparam int CW   = $clog2(MAXN + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_N);
    localparam logic [CW-1:0] REP_C  = CW'(REP_N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          btn_d;

    logic          rise;
    logic [CW-1:0] cnt_inc;
    logic          do_shift;
    logic [W-1:0]  shifted;

    // Decide whether this edge is a shift edge and precompute the shifted value
    always_comb begin
        rise     = btn & ~btn_d;
        cnt_inc  = cnt + CW'(1);
        do_shift = 1'b0;
        case (state)
            IDLE:    do_shift = rise;
            PRESS:   do_shift = btn && (cnt_inc == HOLD_C);
            REPEAT:  do_shift = btn && (cnt_inc == REP_C);
            default: do_shift = 1'b0;
        endcase
        shifted = dir ? {din, q[W-1:1]} : {q[W-2:0], din};
    end

    // Press/repeat FSM with registered register contents and strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            q           <= '0;
            shift_pulse <= 1'b0;
            held        <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            // Treat the button as already seen so a press held across reset is ignored
            btn_d       <= 1'b1;
        end else begin
            btn_d       <= btn;
            // Load wins over a shift, but the FSM still counts the shift as taken
            shift_pulse <= do_shift & ~load;
            if (load)
                q <= load_val;
            else if (do_shift)
                q <= shifted;

            case (state)
                IDLE: begin
                    held <= 1'b0;
                    if (rise) begin
                        cnt   <= '0;
                        state <= PRESS;
                    end
                end
                PRESS: begin
                    if (!btn) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt_inc == HOLD_C) begin
                        cnt   <= '0;
                        state <= REPEAT;
                        held  <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                REPEAT: begin
                    if (!btn) begin
                        cnt   <= '0;
                        state <= IDLE;
                        held  <= 1'b0;
                    end else if (cnt_inc == REP_C) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/btn_shift_ctrl.md
# btn_shift_ctrl

Button-driven shift-register controller that sits directly downstream of the debouncer. It consumes the debounced button level and shifts one bit into a W-bit register on each press. A press held for HOLD_N cycles enters auto-repeat, which shifts once every REP_N cycles until release. The register drives the board LEDs, and a one-cycle strobe is provided for downstream logic.

## Interface
- W, 8: register width, ≥2
- HOLD_N, 10: cycles from first shift to first auto-repeat shift, ≥2
- REP_N, 4: cycles between auto-repeat shifts, ≥2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low; one clock; no other clock or reset in the block
- btn  in  1  debounced button level, 1 = pressed
- dir  in  1  shift direction: 0 = left (toward MSB), 1 = right (toward LSB)
- din  in  1  serial bit shifted in
- load  in  1  synchronous parallel load strobe
- load_val  in  W  parallel load value
- q  out  W  register contents
- shift_pulse  out  1  high for one cycle when q changed by a shift
- held  out  1  high while in auto-repeat

## Operation
- Reset (rst low at a rising edge):
  - q=0, shift_pulse=0, held=0.
  - FSM to IDLE, counter=0.
  - The registered btn copy btn_d is set to 1, so a button already held at reset release causes no shift.
- Rise is defined as btn & !btn_d. btn_d ← btn every non-reset cycle.
- Shift operation:
  - Left: q ← {q[W-2:0], din}.
  - Right: q ← {din, q[W-1:1]}.
  - dir and din are sampled at the shifting edge.
- FSM states:
  - IDLE: on rise, shift, counter←0, go PRESS. Otherwise stay.
  - PRESS:
    - btn=0 → IDLE, no shift.
    - Else counter+1. When the incremented value reaches HOLD_N, shift, counter←0, go REPEAT.
  - REPEAT:
    - btn=0 → IDLE, no shift.
    - Else counter+1. When the incremented value reaches REP_N, shift, counter←0.
- Counter: unsigned, width $clog2(max(HOLD_N,REP_N)+1). Never wraps, since it is always cleared at threshold.
- load=1 has priority over a shift in the same cycle:
  - q←load_val and shift_pulse=0.
  - The FSM and counter advance exactly as if the shift had occurred, so the repeat cadence is unaffected.
- held=1 exactly while state=REPEAT.
- Simultaneous release and threshold: btn=0 wins, with no shift.

## Timing
- All outputs are registered. The block has no combinational input→output path.
- First shift: on the first rising edge sampling btn=1 after a sample of btn=0. q and shift_pulse update at that edge, so latency is 1 edge.
- With btn held, shifts occur at edges E0, E0+HOLD_N, E0+HOLD_N+REP_N, E0+HOLD_N+2·REP_N, …
- held rises together with the E0+HOLD_N shift. It falls at the first edge sampling btn=0.
- shift_pulse is never high on two consecutive cycles, because REP_N≥2.
- Reset mid-press:
  - State clears immediately.
  - After rst returns high, no shift occurs until btn is sampled 0 and then 1.
- A press lasting 1 cycle (btn high at one edge only) still yields exactly one shift.

## Test plan
- Reset: hold rst=0 for 3 cycles with btn=1 and load=1, then release with btn held at 1. Required: q=0x00, shift_pulse=0 and held=0 throughout, and no shift until btn toggles 0→1.
- Single press: W=8, q=0x00, dir=0, din=1, btn high for 3 cycles. Required: q=0x01 one edge after btn first sampled 1, exactly one shift_pulse, held stays 0.
- Auto-repeat: HOLD_N=10, REP_N=4, dir=0, din=1, btn held 20 cycles from E0. Required:
  - shifts at E0, E0+10, E0+14 and E0+18, ending with q=0x0F.
  - held=1 from E0+10 until the edge after release.
- Direction: q=0x80, dir=1, din=0, with three separate presses. Required: q steps 0x40, 0x20, 0x10.
- Load collision: in REPEAT, assert load=1 with load_val=0xA5 in the cycle of a scheduled shift. Required:
  - q=0xA5 and shift_pulse=0 at that edge.
  - The next shift still occurs REP_N cycles later, giving q=0x4B with dir=0 and din=1.
- Release at threshold: in PRESS, drop btn at the edge where the counter would reach HOLD_N. Required: no shift, held stays 0, FSM returns to IDLE, and the next rise shifts once.
